// File: rtl/mult_hs_pkg.sv
// mult_hs_pkg: shared types and sizing helpers for the pipelined handshake multiplier
package mult_hs_pkg;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/mult_hs_fifo.sv
// mult_hs_fifo: synchronous FIFO with async active-low reset, any DEPTH >= 2
module mult_hs_fifo import mult_hs_pkg::*; #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          head,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= nxt(r_wp);
      if (pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= din;
  assign head  = r_mem[r_rp];
  assign count = r_cnt;
`ifndef SYNTHESIS
  always @(posedge clk)
    if (rst) begin
      assert (r_cnt <= CW'(DEPTH)) else $error("fifo count above depth");
      assert (!(push && !pop && r_cnt == CW'(DEPTH))) else $error("fifo write when full");
      assert (!(pop && r_cnt == '0)) else $error("fifo pop when empty");
    end
`endif
endmodule

// File: rtl/mult_hs_pipe.sv
// mult_hs_pipe: pipelined W x W multiplier with credit-based valid/ready and output FIFO
// Optional MULT_HS_STATS_EN adds stat_acc/stat_done/stat_bp counters and trace prints.
module mult_hs_pipe import mult_hs_pkg::*; #(
  parameter int W     = 16,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_a,
  input  logic [W-1:0]            in_b,
  input  logic                    in_signed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*W-1:0]          out_data,
  output logic                    out_signed,
  output logic [cnt_w(DEPTH)-1:0] count
`ifdef MULT_HS_STATS_EN
  ,
  output logic [31:0]             stat_acc,
  output logic [31:0]             stat_done,
  output logic [31:0]             stat_bp
`endif
);
  typedef struct packed {
    logic [2*W-1:0] data;
    logic           sgn;
  } res_t;
  localparam int SW = cnt_w(DEPTH + LAT);
  state_t r_state, w_state_nxt;
  logic [LAT-1:0] r_v;
  res_t r_pipe [LAT];
  res_t w_prod, w_head;
  logic [2*W-1:0] w_ax, w_bx;
  logic [SW-1:0] w_inflight;
  logic w_acc, w_pop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= INIT;
    else r_state <= w_state_nxt;
  always_comb w_state_nxt = r_state == INIT ? RUN : r_state;
  // Extending both operands to 2W and keeping the low 2W bits gives the exact signed product.
  assign w_ax   = {{W{in_signed & in_a[W-1]}}, in_a};
  assign w_bx   = {{W{in_signed & in_b[W-1]}}, in_b};
  assign w_prod = '{data: w_ax * w_bx, sgn: in_signed};
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight += SW'(r_v[i]);
  end
  // Credits count both buffered and in-flight results, so a push always finds room.
  assign in_ready  = r_state == RUN && (SW'(count) + w_inflight < SW'(DEPTH));
  assign w_acc     = in_valid && in_ready;
  assign out_valid = count != '0;
  assign w_pop     = out_valid && out_ready;
  assign {out_data, out_signed} = out_valid ? w_head : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_v <= '0;
    else begin
      r_v[0] <= w_acc;
      for (int i = 1; i < LAT; i++) r_v[i] <= r_v[i-1];
    end
  always_ff @(posedge clk) begin
    r_pipe[0] <= w_prod;
    for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end
  mult_hs_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_v[LAT-1]),
    .pop   (w_pop),
    .din   (r_pipe[LAT-1]),
    .head  (w_head),
    .count (count)
  );
`ifdef MULT_HS_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_acc  <= '0;
      stat_done <= '0;
      stat_bp   <= '0;
    end else begin
      stat_acc  <= stat_acc + 32'(w_acc && stat_acc != '1);
      stat_done <= stat_done + 32'(w_pop && stat_done != '1);
      stat_bp   <= stat_bp + 32'(out_valid && !out_ready && stat_bp != '1);
    end
  always @(posedge clk)
    if (rst) begin
      if (w_acc) $display("mult_hs_pipe accept a=%0d b=%0d a=%b b=%b signed=%0b", in_a, in_b, in_a, in_b, in_signed);
      if (w_pop) $display("mult_hs_pipe pop product=%0d product=%b signed=%0b", out_data, out_data, out_signed);
    end
`endif
endmodule
